// File: rtl/byte_strip_if.sv
// Byte-striper bus: serial byte input side plus the registered four-lane group output.
// The master drives the byte stream; the slave (byte_strip) drives the lanes and status.
interface byte_strip_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       d;
    logic             dk;
    logic             valid;
    logic             flush;
    logic [7:0]       lane0;
    logic [7:0]       lane1;
    logic [7:0]       lane2;
    logic [7:0]       lane3;
    logic             dk_0;
    logic             dk_1;
    logic             dk_2;
    logic             dk_3;
    logic             lane_valid;
    logic             busy;
    logic [CNT_W-1:0] group_cnt;

    modport master (
        output d, dk, valid, flush,
        input  lane0, lane1, lane2, lane3, dk_0, dk_1, dk_2, dk_3,
        input  lane_valid, busy, group_cnt
    );

    modport slave (
        input  d, dk, valid, flush,
        output lane0, lane1, lane2, lane3, dk_0, dk_1, dk_2, dk_3,
        output lane_valid, busy, group_cnt
    );
endinterface

// File: rtl/byte_strip.sv
// Transmit-side byte striper: gathers four serial bytes (with K/D flag) into one lane group,
// padding a partial group with PAD_CHAR on flush. Lanes change only on emit cycles.
module byte_strip #(
    parameter logic [7:0] PAD_CHAR = 8'hF7,
    parameter int         CNT_W    = 16
) (
    input logic          clk,
    input logic          reset_l,
    byte_strip_if.slave  bus
);
    typedef enum logic [1:0] {S0, S1, S2, S3} ptr_t;

    ptr_t             ptr;
    ptr_t             ptr_nxt;
    logic             emit;
    logic             capture;
    logic [8:0]       grp [4];
    logic [8:0]       shadow [4];
    logic [8:0]       lane_q [4];
    logic             lane_valid_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_l) ptr <= S0;
        else          ptr <= ptr_nxt;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        ptr_nxt = ptr;
        emit    = 1'b0;
        capture = 1'b0;
        for (int i = 0; i < 4; i++) grp[i] = {1'b1, PAD_CHAR};

        if (bus.valid) begin
            if (ptr == S3 || bus.flush) begin
                emit    = 1'b1;
                ptr_nxt = S0;
            end else begin
                capture = 1'b1;
                ptr_nxt = ptr_t'(ptr + 2'd1);
            end
        end else if (bus.flush && ptr != S0) begin
            emit    = 1'b1;
            ptr_nxt = S0;
        end

        // Lanes below the pointer come from the shadow; the live byte lands at the pointer.
        for (int i = 0; i < 3; i++) begin
            if (i < int'(ptr)) grp[i] = shadow[i];
        end
        if (bus.valid) grp[ptr] = {bus.dk, bus.d};
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            // NOTE: the shadow store is reset too, so a partial group is discarded outright.
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                lane_q[i] <= '0;
            end
            lane_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            lane_valid_q <= emit;
            if (capture) shadow[ptr] <= {bus.dk, bus.d};
            if (emit) begin
                for (int i = 0; i < 4; i++) lane_q[i] <= grp[i];
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.lane0      = lane_q[0][7:0];
    assign bus.lane1      = lane_q[1][7:0];
    assign bus.lane2      = lane_q[2][7:0];
    assign bus.lane3      = lane_q[3][7:0];
    assign bus.dk_0       = lane_q[0][8];
    assign bus.dk_1       = lane_q[1][8];
    assign bus.dk_2       = lane_q[2][8];
    assign bus.dk_3       = lane_q[3][8];
    assign bus.lane_valid = lane_valid_q;
    assign bus.busy       = (ptr != S0);
    assign bus.group_cnt  = cnt_q;
endmodule
